// File: rtl/main_decoder.sv
// main_decoder: RISC-V opcode decoder into datapath controls, with illegal-opcode debug status.
// Define MAIN_DECODER_ITYPE_EN to also decode I-type ALU instructions (0010011).
module main_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       Op,
   input  logic             OpValid,
   input  logic             ClrStatus,
   output logic             RegWrite,
   output logic [1:0]       ImmSrc,
   output logic             ALUSrc,
   output logic             MemWrite,
   output logic             ResultSrc,
   output logic             Branch,
   output logic [1:0]       ALUOp,
   output logic             IllegalOp,
   output logic             IllegalSticky,
   output logic [CNT_W-1:0] IllegalCount
);
`ifdef MAIN_DECODER_ITYPE_EN
   localparam bit ITYPE_EN = 1'b1;
`else
   localparam bit ITYPE_EN = 1'b0;
`endif
   logic [8:0] ctrl;
   // Unlisted opcodes fall to all-zero controls: no write, no store, no branch.
   always_comb begin
      ctrl = (Op == 7'b0000011)             ? 9'b1_00_1_0_1_0_00 :
             (Op == 7'b0100011)             ? 9'b0_01_1_1_0_0_00 :
             (Op == 7'b0110011)             ? 9'b1_00_0_0_0_0_10 :
             (Op == 7'b1100011)             ? 9'b0_10_0_0_0_1_01 :
             (ITYPE_EN && Op == 7'b0010011) ? 9'b1_00_1_0_0_0_10 : 9'b0;
      IllegalOp = !(Op == 7'b0000011 || Op == 7'b0100011 || Op == 7'b0110011 ||
                    Op == 7'b1100011 || (ITYPE_EN && Op == 7'b0010011));
   end
   assign {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp} = ctrl;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IllegalSticky <= 1'b0;
         IllegalCount  <= '0;
      end else if (ClrStatus) begin
         IllegalSticky <= 1'b0;
         IllegalCount  <= '0;
      end else if (OpValid && IllegalOp) begin
         IllegalSticky <= 1'b1;
         if (IllegalCount != '1) IllegalCount <= IllegalCount + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_main_decoder.sv
// tb_main_decoder: scoreboard bench for main_decoder against a table-driven reference model.
// Honours MAIN_DECODER_ITYPE_EN the same way the design does.
module tb_main_decoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] Op = 7'h00;
   logic       OpValid = 1'b0;
   logic       ClrStatus = 1'b0;
   logic       RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, IllegalOp, IllegalSticky;
   logic [1:0] ImmSrc, ALUOp;
   logic [7:0] IllegalCount;
   int         nChecks = 0;
   int         nFail = 0;
   logic [18:0] sbQueue[$];
   int         modCount = 0;
   bit         modSticky = 1'b0;

   main_decoder #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .Op(Op), .OpValid(OpValid), .ClrStatus(ClrStatus),
      .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
      .ResultSrc(ResultSrc), .Branch(Branch), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
      .IllegalSticky(IllegalSticky), .IllegalCount(IllegalCount)
   );

   always #5 clk = ~clk;

   // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, IllegalOp}
   function automatic logic [9:0] refComb(input logic [6:0] op);
      case (op)
         7'b0000011: return 10'b1_00_1_0_1_0_00_0;
         7'b0100011: return 10'b0_01_1_1_0_0_00_0;
         7'b0110011: return 10'b1_00_0_0_0_0_10_0;
         7'b1100011: return 10'b0_10_0_0_0_1_01_0;
`ifdef MAIN_DECODER_ITYPE_EN
         7'b0010011: return 10'b1_00_1_0_0_0_10_0;
`endif
         default:    return 10'b0_00_0_0_0_0_00_1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [6:0] op, input logic valid, input logic clr);
      logic [9:0] c;
      @(posedge clk);
      #1;
      Op = op;
      OpValid = valid;
      ClrStatus = clr;
      c = refComb(op);
      sbQueue.push_back({c, modSticky, 8'(modCount)});
      if (clr) begin
         modSticky = 1'b0;
         modCount = 0;
      end else if (valid && c[0]) begin
         modSticky = 1'b1;
         modCount = (modCount < 255) ? modCount + 1 : 255;
      end
   endtask

   initial begin : monitor
      logic [18:0] e;
      forever begin
         @(negedge clk);
         if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            chk("scoreboard", {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp,
                               IllegalOp, IllegalSticky, IllegalCount}, e);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin : stim
      logic [6:0] ops[5] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13};
      repeat (3) @(posedge clk);
      #2;
      chk("reset_status", {IllegalSticky, IllegalCount}, 9'h0);
      @(negedge clk);
      rst = 1'b0;
      // every opcode class once, then random traffic
      for (int i = 0; i < 5; i++) step(ops[i], 1'b1, 1'b0);
      step(7'h7f, 1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         logic [6:0] op;
         op = ($urandom_range(0, 9) < 6) ? ops[$urandom_range(0, 4)] : 7'($urandom);
         step(op, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      // three illegal valid cycles, then invalid cycles must hold
      step(7'h00, 1'b0, 1'b1);
      repeat (3) step(7'h7f, 1'b1, 1'b0);
      step(7'h7f, 1'b0, 1'b0);
      @(negedge clk);
      chk("count_three", {IllegalOp, IllegalSticky, IllegalCount}, {1'b1, 1'b1, 8'd3});
      repeat (2) step(7'h7f, 1'b0, 1'b0);
      @(negedge clk);
      chk("count_hold", IllegalCount, 8'd3);
      // saturation
      repeat (300) step(7'h7f, 1'b1, 1'b0);
      step(7'h7f, 1'b0, 1'b0);
      @(negedge clk);
      chk("count_saturate", IllegalCount, 8'd255);
      step(7'h7f, 1'b1, 1'b1);
      step(7'h7f, 1'b0, 1'b0);
      @(negedge clk);
      chk("clear_priority", {IllegalSticky, IllegalCount}, 9'h0);
      repeat (5) step(7'h55, 1'b1, 1'b0);
      step(7'h7f, 1'b0, 1'b0);
      // asynchronous reset in mid-cycle
      wait (sbQueue.size() == 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_reset", {IllegalSticky, IllegalCount}, 9'h0);
      modSticky = 1'b0;
      modCount = 0;
      #1;
      rst = 1'b0;
      step(7'h23, 1'b1, 1'b0);
      step(7'h7f, 1'b1, 1'b0);
      step(7'h13, 1'b1, 1'b0);
      step(7'h13, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      if (sbQueue.size() != 0) begin
         nChecks++;
         nFail++;
         $display("FAIL drain actual=%0d required=0", sbQueue.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
